memory_pipelined: RTL and testbench

//  Parametrised single-port data memory: successor to the 32-bit fixed-latency store.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_resp_fifo.sv | 60 ++++++
 rtl/memory_pipelined.sv | 137 +++++++++++++
 tb/tb_memory_pipelined.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for memory_pipelined: response entry, latency bound, byte parity.
package mem_pkg;

    localparam int RD_LAT_MAX  = 4;
    localparam int RESP_DATA_W = 32;

    // Default response entry; the top re-declares it at its own DATA_W.
    typedef struct packed {
        logic [RESP_DATA_W-1:0] data;
        logic                   err;
    } resp_t;

    // Even parity: stored bit makes the 9-bit group have an even number of ones.
    function automatic logic byte_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// Response queue for memory_pipelined: DEPTH-entry ring buffer, one push and one pop per cycle.
module mem_resp_fifo
    import mem_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = resp_t
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  entry_t                       push_data_i,
    input  logic                         pop_i,
    output entry_t                       head_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    entry_t          ram_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push_ok, pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // Pop on empty is ignored; push on full only lands if a pop frees the slot.
    assign pop_ok  = pop_i && (cnt_q != '0);
    assign push_ok = push_i && ((cnt_q != CW'(DEPTH)) || pop_ok);

    always_comb begin
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) ram_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = ram_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/memory_pipelined.sv
// Single-port data memory with valid/ready requests, RD_LAT read pipeline and credited response queue.
// Optional MEMORY_PARITY_EN stores one even-parity bit per byte and flags mismatches on read.
module memory_pipelined
    import mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int DEPTH      = 65536,
    parameter int RD_LAT     = 1,
    parameter int RESP_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [DATA_W/8-1:0]  req_be,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [DATA_W-1:0]    resp_rdata,
    output logic                 resp_err,
    output logic                 err_sticky
);

    localparam int BE_W = DATA_W / 8;
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW   = $clog2(RESP_DEPTH+1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("memory_pipelined: RD_LAT out of range");
    end
    if (RESP_DEPTH < RD_LAT + 1) begin : g_bad_depth
        $error("memory_pipelined: RESP_DEPTH must be >= RD_LAT+1");
    end

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } rsp_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IW-1:0]     idx;
    logic              in_range, accept, rd_acc, wr_acc, pop, par_bad;
    logic [RD_LAT:1]   vld_pipe_q;
    rsp_t              pipe_q [1:RD_LAT];
    rsp_t              rd_rsp, head;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_cnt, outstanding;
    logic              err_sticky_q;

    assign idx      = req_addr[IW-1:0];
    assign in_range = {1'b0, req_addr} < DEPTH_L;
    assign accept   = req_valid && req_ready;
    assign rd_acc   = accept && !req_we;
    assign wr_acc   = accept && req_we;
    assign pop      = resp_valid && resp_ready;

    // Credits: reads in the pipeline plus queued responses.
    always_comb begin
        outstanding = fifo_cnt;
        for (int i = 1; i <= RD_LAT; i++) outstanding = outstanding + CW'(vld_pipe_q[i]);
    end

    // A same-cycle pop frees its slot, so full-rate reads need only RD_LAT+1 entries.
    assign req_ready = !reset && ((outstanding - CW'(pop)) < CW'(RESP_DEPTH));

`ifdef MEMORY_PARITY_EN
    logic [BE_W-1:0] par_q [DEPTH];
    always_comb begin
        par_bad = 1'b0;
        for (int b = 0; b < BE_W; b++)
            if (byte_par(mem_q[idx][8*b +: 8]) != par_q[idx][b]) par_bad = 1'b1;
    end
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            for (int b = 0; b < BE_W; b++) begin
                if (req_be[b]) begin
                    mem_q[idx][8*b +: 8] <= req_wdata[8*b +: 8];
`ifdef MEMORY_PARITY_EN
                    par_q[idx][b] <= byte_par(req_wdata[8*b +: 8]);
`endif
                end
            end
        end
    end

    always_comb begin
        rd_rsp.data = in_range ? mem_q[idx] : '0;
        rd_rsp.err  = !in_range || par_bad;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q[1] <= rd_acc;
            for (int i = 2; i <= RD_LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pipe_q[1] <= rd_rsp;
        for (int i = 2; i <= RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (reset)                    err_sticky_q <= 1'b0;
        else if (wr_acc && !in_range) err_sticky_q <= 1'b1;
    end

    mem_resp_fifo #(
        .DEPTH   (RESP_DEPTH),
        .entry_t (rsp_t)
    ) u_resp_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (vld_pipe_q[RD_LAT]),
        .push_data_i (pipe_q[RD_LAT]),
        .pop_i       (pop),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_cnt)
    );

    assign resp_valid = !fifo_empty;
    assign resp_rdata = fifo_empty ? '0 : head.data;
    assign resp_err   = !fifo_empty && head.err;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_memory_pipelined.sv
// Randomised bench for memory_pipelined against a word-array/queue reference model.
module tb_memory_pipelined;

    localparam int DATA_W = 32, ADDR_W = 16, DEPTH = 1024, RD_LAT = 3, RESP_DEPTH = 4;

    logic              clk = 1'b0, reset = 1'b1;
    logic              req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [3:0]        req_be = '0;
    logic              req_ready, resp_valid, resp_err, err_sticky;
    logic [DATA_W-1:0] resp_rdata;

    memory_pipelined #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .RESP_DEPTH(RESP_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_bad = 0;
    logic [31:0] model [int];
    logic [31:0] exp_d [$], got_d [$];
    logic        exp_e [$], got_e [$];
    bit          last_acc;

    // One clock: observe handshakes mid-cycle, update the model, then move past the edge.
    task automatic step();
        logic [31:0] w;
        @(negedge clk);
        last_acc = req_valid && req_ready;
        if (reset) begin
            exp_d.delete(); exp_e.delete(); got_d.delete(); got_e.delete();
        end else begin
            if (resp_valid && resp_ready) begin
                got_d.push_back(resp_rdata);
                got_e.push_back(resp_err);
            end
            if (last_acc && req_we && int'(req_addr) < DEPTH) begin
                w = model.exists(int'(req_addr)) ? model[int'(req_addr)] : 32'h0;
                for (int b = 0; b < 4; b++) if (req_be[b]) w[8*b +: 8] = req_wdata[8*b +: 8];
                model[int'(req_addr)] = w;
            end else if (last_acc && !req_we) begin
                exp_d.push_back(int'(req_addr) < DEPTH ? model[int'(req_addr)] : 32'h0);
                exp_e.push_back(int'(req_addr) >= DEPTH);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input bit we, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] be, output bit ok);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            ok = last_acc;
        end
        req_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        resp_ready = 1'b1;
        for (int i = 0; i < 200 && got_d.size() < n; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1; resp_ready = 1'b0; req_valid = 1'b0;
        step(); step();
        n_cmp++;
        if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_low: got %b want 0", req_ready); end
        reset = 1'b0;
        step();
        n_cmp++;
        if ({resp_valid, resp_err, err_sticky} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000", {resp_valid, resp_err, err_sticky});
        end
        n_cmp++;
        if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        n_cmp++;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b want 1", req_ready); end
    endtask

    task automatic test_basic_rw();
        bit ok;
        int lat;
        resp_ready = 1'b1;
        do_req(1'b1, 16'h10, 32'hDEADBEEF, 4'hF, ok);
        do_req(1'b0, 16'h10, 32'h0, 4'h0, ok);
        lat = 0;
        for (int i = 0; i < 20 && got_d.size() == 0; i++) begin step(); lat++; end
        n_cmp++;
        if (lat !== RD_LAT + 1) begin n_bad++; $display("FAIL read_latency: got %0d want %0d", lat, RD_LAT + 1); end
        n_cmp++;
        if (got_d.size() != 1 || got_d[0] !== 32'hDEADBEEF || got_e[0] !== 1'b0) begin
            n_bad++; $display("FAIL basic_read: got %0d resp(s), first %h want DEADBEEF err 0", got_d.size(),
                              got_d.size() ? got_d[0] : 32'h0);
        end
        got_d.delete(); got_e.delete(); exp_d.delete(); exp_e.delete();
    endtask

    task automatic test_byte_enable();
        bit ok;
        logic [15:0] a;
        do_req(1'b1, 16'h20, 32'h11223344, 4'hF, ok);
        do_req(1'b1, 16'h20, 32'hAABBCCDD, 4'b0101, ok);
        do_req(1'b0, 16'h20, 32'h0, 4'h0, ok);
        do_req(1'b1, 16'h20, 32'hFFFFFFFF, 4'b0000, ok);
        do_req(1'b0, 16'h20, 32'h0, 4'h0, ok);
        drain(2);
        n_cmp++;
        if (got_d.size() != 2 || got_d[0] !== 32'h11BB33DD || got_d[1] !== 32'h11BB33DD) begin
            n_bad++; $display("FAIL byte_enable: got %0d resp(s) %h want 11BB33DD twice", got_d.size(),
                              got_d.size() ? got_d[0] : 32'h0);
        end
        got_d.delete(); got_e.delete(); exp_d.delete(); exp_e.delete();
        for (int k = 0; k < 8; k++) begin
            a = 16'h40 + 16'($urandom_range(0, 63));
            do_req(1'b1, a, $urandom, 4'hF, ok);
            do_req(1'b1, a, $urandom, 4'($urandom), ok);
            do_req(1'b0, a, 32'h0, 4'h0, ok);
        end
        drain(8);
        n_cmp++;
        if (got_d.size() != exp_d.size()) begin n_bad++; $display("FAIL be_random_count: got %0d want %0d", got_d.size(), exp_d.size()); end
        while (got_d.size() > 0 && exp_d.size() > 0) begin
            n_cmp++;
            if (got_d[0] !== exp_d[0]) begin n_bad++; $display("FAIL be_random_data: got %h want %h", got_d[0], exp_d[0]); end
            void'(got_d.pop_front()); void'(exp_d.pop_front());
        end
        got_e.delete(); exp_e.delete();
    endtask

    task automatic test_credit();
        bit ok;
        int nacc = 0;
        for (int k = 0; k < 6; k++) do_req(1'b1, 16'h100 + 16'(k), $urandom, 4'hF, ok);
        resp_ready = 1'b0;
        req_we = 1'b0;
        for (int c = 0; c < 12; c++) begin
            req_valid = (nacc < 6); req_addr = 16'h100 + 16'(nacc);
            step();
            if (last_acc) nacc++;
        end
        n_cmp++;
        if (nacc !== RESP_DEPTH) begin n_bad++; $display("FAIL credit_accepts: got %0d want %0d", nacc, RESP_DEPTH); end
        n_cmp++;
        if (req_ready !== 1'b0) begin n_bad++; $display("FAIL credit_ready_low: got %b want 0", req_ready); end
        resp_ready = 1'b1;
        for (int c = 0; c < 50 && (nacc < 6 || got_d.size() < 6); c++) begin
            req_valid = (nacc < 6); req_addr = 16'h100 + 16'(nacc);
            step();
            if (last_acc) nacc++;
        end
        req_valid = 1'b0;
        n_cmp++;
        if (got_d.size() != 6) begin n_bad++; $display("FAIL credit_resp_count: got %0d want 6", got_d.size()); end
        while (got_d.size() > 0 && exp_d.size() > 0) begin
            n_cmp++;
            if (got_d[0] !== exp_d[0]) begin n_bad++; $display("FAIL credit_order: got %h want %h", got_d[0], exp_d[0]); end
            void'(got_d.pop_front()); void'(exp_d.pop_front());
        end
        got_e.delete(); exp_e.delete(); exp_d.delete();
    endtask

    task automatic test_out_of_range();
        bit ok;
        logic [31:0] w0;
        w0 = $urandom;
        do_req(1'b1, 16'h000, w0, 4'hF, ok);
        do_req(1'b1, 16'h3FF, $urandom, 4'hF, ok);
        n_cmp++;
        if (err_sticky !== 1'b0) begin n_bad++; $display("FAIL sticky_clear: got %b want 0", err_sticky); end
        do_req(1'b0, 16'h400, 32'h0, 4'h0, ok);
        do_req(1'b0, 16'hFFFF, 32'h0, 4'h0, ok);
        do_req(1'b0, 16'h3FF, 32'h0, 4'h0, ok);
        drain(3);
        n_cmp++;
        if (got_d.size() != 3) begin n_bad++; $display("FAIL range_count: got %0d want 3", got_d.size()); end
        while (got_d.size() > 0 && exp_d.size() > 0) begin
            n_cmp++;
            if ({got_e[0], got_d[0]} !== {exp_e[0], exp_d[0]}) begin
                n_bad++; $display("FAIL range_read: got err %b data %h want err %b data %h", got_e[0], got_d[0], exp_e[0], exp_d[0]);
            end
            void'(got_d.pop_front()); void'(exp_d.pop_front()); void'(got_e.pop_front()); void'(exp_e.pop_front());
        end
        do_req(1'b1, 16'h400, ~w0, 4'hF, ok);
        step();
        n_cmp++;
        if (err_sticky !== 1'b1) begin n_bad++; $display("FAIL sticky_set: got %b want 1", err_sticky); end
        do_req(1'b1, 16'h001, $urandom, 4'hF, ok);
        do_req(1'b0, 16'h000, 32'h0, 4'h0, ok);
        drain(1);
        n_cmp++;
        if (err_sticky !== 1'b1) begin n_bad++; $display("FAIL sticky_hold: got %b want 1", err_sticky); end
        n_cmp++;
        if (got_d.size() != 1 || got_d[0] !== w0) begin
            n_bad++; $display("FAIL range_write_dropped: got %h want %h", got_d.size() ? got_d[0] : 32'h0, w0);
        end
        got_d.delete(); got_e.delete(); exp_d.delete(); exp_e.delete();
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [15:0] addrs [16];
        int nacc = 0, stalls = 0, first_pop = -1, last_pop = -1, seen = 0;
        for (int k = 0; k < 16; k++) begin
            addrs[k] = 16'($urandom_range(0, DEPTH - 1));
            do_req(1'b1, addrs[k], $urandom, 4'hF, ok);
        end
        resp_ready = 1'b1; req_we = 1'b0;
        for (int c = 0; c < 80 && (nacc < 16 || got_d.size() < 16); c++) begin
            req_valid = (nacc < 16); req_addr = addrs[nacc % 16];
            step();
            if (last_acc) nacc++;
            else if (req_valid) stalls++;
            if (got_d.size() > seen) begin
                seen = got_d.size();
                if (first_pop < 0) first_pop = c;
                last_pop = c;
            end
        end
        req_valid = 1'b0;
        n_cmp++;
        if (stalls !== 0) begin n_bad++; $display("FAIL b2b_accept_stalls: got %0d want 0", stalls); end
        n_cmp++;
        if (last_pop - first_pop !== 15) begin n_bad++; $display("FAIL b2b_resp_span: got %0d want 15", last_pop - first_pop); end
        n_cmp++;
        if (got_d.size() != 16) begin n_bad++; $display("FAIL b2b_count: got %0d want 16", got_d.size()); end
        while (got_d.size() > 0 && exp_d.size() > 0) begin
            n_cmp++;
            if (got_d[0] !== exp_d[0]) begin n_bad++; $display("FAIL b2b_order: got %h want %h", got_d[0], exp_d[0]); end
            void'(got_d.pop_front()); void'(exp_d.pop_front());
        end
        got_e.delete(); exp_e.delete(); exp_d.delete();
    endtask

    task automatic test_reset_inflight();
        int nacc = 0;
        resp_ready = 1'b1; req_we = 1'b0;
        for (int c = 0; c < 10 && nacc < 3; c++) begin
            req_valid = 1'b1; req_addr = 16'h100 + 16'(nacc);
            step();
            if (last_acc) nacc++;
        end
        req_valid = 1'b0; resp_ready = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        n_cmp++;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL inflight_ready: got %b want 1", req_ready); end
        n_cmp++;
        if (err_sticky !== 1'b0) begin n_bad++; $display("FAIL inflight_sticky_cleared: got %b want 0", err_sticky); end
        resp_ready = 1'b1;
        for (int c = 0; c < 8; c++) step();
        n_cmp++;
        if (got_d.size() != 0) begin n_bad++; $display("FAIL inflight_discarded: got %0d resp(s) want 0", got_d.size()); end
        got_d.delete(); got_e.delete(); exp_d.delete(); exp_e.delete();
    endtask

`ifdef MEMORY_PARITY_EN
    task automatic test_parity();
        bit ok;
        resp_ready = 1'b1;
        do_req(1'b1, 16'h30, 32'hDEADBEEF, 4'hF, ok);
        do_req(1'b0, 16'h30, 32'h0, 4'h0, ok);
        drain(1);
        n_cmp++;
        if (got_e.size() != 1 || got_e[0] !== 1'b0) begin n_bad++; $display("FAIL parity_clean: got err %b want 0", got_e.size() ? got_e[0] : 1'bx); end
        got_d.delete(); got_e.delete(); exp_d.delete(); exp_e.delete();
        dut.par_q[48] = dut.par_q[48] ^ 4'b0010;
        do_req(1'b0, 16'h30, 32'h0, 4'h0, ok);
        drain(1);
        n_cmp++;
        if (got_e.size() != 1 || got_e[0] !== 1'b1 || got_d[0] !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL parity_flip: got err %b data %h want err 1 data DEADBEEF",
                              got_e.size() ? got_e[0] : 1'bx, got_d.size() ? got_d[0] : 32'h0);
        end
        got_d.delete(); got_e.delete(); exp_d.delete(); exp_e.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_basic_rw();
        test_byte_enable();
        test_credit();
        test_out_of_range();
        test_back_to_back();
        test_reset_inflight();
`ifdef MEMORY_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
